exec_stage_pipe: RTL

Parametrised, handshaked successor to the LC3 execution stage. It selects operands (PC/RS1, RS2/sign-extended IR field) and computes single-cycle ALU ops or an iterative multiply. It drives registered Y/NPZ/OF to the writeback stage. It sits between decode/regfile read and writeback, and adds valid/ready flow control, FLUSH, and a multi-cycle MUL mode.

---
 rtl/exec_pkg.sv | 38 +++
 rtl/seq_mul.sv | 50 +++++
 rtl/exec_stage_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execution stage: opcodes, operand-B selects,
// FSM encoding, NPZ bit positions and the immediate sign-extend helper.
package exec_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // ALU_MuxB codes 0xx all select RS2_DATA; bit 2 set selects an IR field.
    localparam logic [1:0] MUXB_IMM5  = 2'b00;
    localparam logic [1:0] MUXB_OFF6  = 2'b01;
    localparam logic [1:0] MUXB_OFF9  = 2'b10;
    localparam logic [1:0] MUXB_OFF11 = 2'b11;

    localparam int NPZ_N = 2;
    localparam int NPZ_P = 1;
    localparam int NPZ_Z = 0;

    localparam int SEXT_W = 64;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // Sign-extends the low fw bits of an 11-bit IR field to SEXT_W bits.
    function automatic logic [SEXT_W-1:0] sext(input logic [10:0] field, input int fw);
        logic signed [SEXT_W-1:0] t;
        t = $signed({field << (11 - fw), {(SEXT_W-11){1'b0}}});
        return t >>> (SEXT_W - fw);
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative unsigned radix-2 shift-add multiplier, one multiplier bit per edge.
// done is high during the cycle whose closing edge performs the final iteration.
module seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               active;

    assign active  = (count != '0);
    assign done    = (count == CW'(1));
    // product already includes the iteration taken at the next edge
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (abort) begin
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= CW'(WIDTH);
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/exec_stage_pipe.sv
// Handshaked execution stage: operand select, single-cycle ALU, iterative signed
// multiply, registered Y/NPZ/OF towards writeback.
module exec_stage_pipe
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int IR_W   = 16,
    parameter int MUL_EN = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       ALU_CONTROL,
    input  logic             ALU_MuxA,
    input  logic [2:0]       ALU_MuxB,
    input  logic [WIDTH-1:0] PC,
    input  logic [IR_W-1:0]  IR,
    input  logic [WIDTH-1:0] RS1_DATA,
    input  logic [WIDTH-1:0] RS2_DATA,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic [2:0]       NPZ,
    output logic             OF,
    output logic             BUSY,
    output logic             dbg_state
);

    localparam logic [2*WIDTH-1:0] MAG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   op_a, op_b, imm, sum, diff, alu_y, mag_a, mag_b, mul_y;
    logic [2*WIDTH-1:0] mul_mag;
    logic               alu_of, mul_of, mul_neg, mul_done, is_mul, accept, mul_start;
    logic               unused_ir;

    assign unused_ir = ^IR[IR_W-1:11];
    assign dbg_state = state;

    function automatic logic [2:0] npz_of(input logic [WIDTH-1:0] v);
        npz_of = '0;
        if (v == '0)          npz_of[NPZ_Z] = 1'b1;
        else if (v[WIDTH-1])  npz_of[NPZ_N] = 1'b1;
        else                  npz_of[NPZ_P] = 1'b1;
    endfunction

    always_comb begin
        imm = '0;
        case (ALU_MuxB[1:0])
            MUXB_IMM5:  imm = WIDTH'(sext(IR[10:0], 5));
            MUXB_OFF6:  imm = WIDTH'(sext(IR[10:0], 6));
            MUXB_OFF9:  imm = WIDTH'(sext(IR[10:0], 9));
            MUXB_OFF11: imm = WIDTH'(sext(IR[10:0], 11));
            default:    imm = '0;
        endcase
    end

    assign op_a   = ALU_MuxA ? RS1_DATA : PC;
    assign op_b   = ALU_MuxB[2] ? imm : RS2_DATA;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;
    assign is_mul = (MUL_EN != 0) && (ALU_CONTROL == OP_MUL);

    always_comb begin
        alu_y  = op_b;
        alu_of = 1'b0;
        case (ALU_CONTROL)
            OP_ADD: begin
                alu_y  = sum;
                alu_of = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y  = diff;
                alu_of = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  alu_y = op_a & op_b;
            OP_NOT:  alu_y = ~op_a;
            OP_OR:   alu_y = op_a | op_b;
            OP_XOR:  alu_y = op_a ^ op_b;
            default: alu_y = op_b;   // PASS, and MUL when the multiplier is disabled
        endcase
    end

    assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

    seq_mul #(.WIDTH(WIDTH)) u_seq_mul (
        .clk     (CLK),
        .rst_n   (RST_N),
        .start   (mul_start),
        .abort   (FLUSH),
        .a       (mag_a),
        .b       (mag_b),
        .done    (mul_done),
        .product (mul_mag)
    );

    // -2^(WIDTH-1) is the one negative result whose magnitude exceeds the positive range.
    assign mul_y  = mul_neg ? -mul_mag[WIDTH-1:0] : mul_mag[WIDTH-1:0];
    assign mul_of = mul_neg ? (mul_mag > MAG_LIM) : (mul_mag >= MAG_LIM);

    // Handshake: a transfer happens at a rising edge where valid and ready are both
    // high; ready never depends on valid from the same side, and a held result keeps
    // Y/NPZ/OF stable until OUT_READY takes it.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        BUSY      = 1'b0;
        case (state)
            IDLE:     IN_READY = !OUT_VALID || OUT_READY;
            MUL_BUSY: BUSY     = 1'b1;
            default:  IN_READY = 1'b0;
        endcase
        if (FLUSH) IN_READY = 1'b0;
        accept    = IN_VALID && IN_READY;
        mul_start = accept && is_mul;
        if (FLUSH)                              state_nxt = IDLE;
        else if (state == IDLE && mul_start)    state_nxt = MUL_BUSY;
        else if (state == MUL_BUSY && mul_done) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            Y         <= '0;
            NPZ       <= 3'b001;
            OF        <= 1'b0;
            mul_neg   <= 1'b0;
        end else begin
            if (mul_start) mul_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            if (FLUSH) begin
                OUT_VALID <= 1'b0;
            end else if (accept && !is_mul) begin
                Y         <= alu_y;
                NPZ       <= npz_of(alu_y);
                OF        <= alu_of;
                OUT_VALID <= 1'b1;
            end else if (state == MUL_BUSY && mul_done) begin
                Y         <= mul_y;
                NPZ       <= npz_of(mul_y);
                OF        <= mul_of;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule
